// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, counter width default and the
// NOP word that flushed pipeline registers are loaded with.
package pipe_ctrl_pkg;

  localparam logic [1:0] CTRL_RUN    = 2'd0;
  localparam logic [1:0] CTRL_DRAIN  = 2'd1;
  localparam logic [1:0] CTRL_HALTED = 2'd2;

  typedef enum logic [1:0] {
    StRun    = CTRL_RUN,
    StDrain  = CTRL_DRAIN,
    StHalted = CTRL_HALTED
  } ctrl_state_e;

  localparam int unsigned CntWDefault = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NopInsn = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that a load in EX
// has not yet produced.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wen_i,
  input  logic       ex_is_load_i,
  output logic       lu_o
);

  logic ex_load_wr;
  logic rs1_match;
  logic rs2_match;

  always_comb begin
    // x0 is never a real dependency
    ex_load_wr = ex_is_load_i && ex_reg_wen_i && (ex_rd_addr_i != 5'd0);
    rs1_match  = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_match  = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    lu_o       = ex_load_wr && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: hold/flush/redirect controls, debug halt/drain
// handshake and saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_reg_wen_i,
  input  logic             ex_is_load_i,
  input  logic             ex_jump_en_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             mem_busy_i,
  input  logic             halt_req_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_hold_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             halt_ack_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  ctrl_state_e      state_q;
  logic [DcW-1:0]   drain_cnt_q;
  logic             halt_ack_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic lu;
  logic busy_stall;
  logic lu_stall;
  logic redirect;

  hazard_detect u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_reg_wen_i  (ex_reg_wen_i),
    .ex_is_load_i  (ex_is_load_i),
    .lu_o          (lu)
  );

  always_comb begin
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_hold_o  = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_mem_hold_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    busy_stall    = 1'b0;
    lu_stall      = 1'b0;
    redirect      = 1'b0;
    // Outputs are gated by reset so they drop without waiting for a clock edge
    if (rst_n) begin
      if (state_q == StHalted) begin
        pc_hold_o     = 1'b1;
        if_id_flush_o = 1'b1;
      end else if (mem_busy_i) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_hold_o  = 1'b1;
        ex_mem_hold_o = 1'b1;
        busy_stall    = 1'b1;
      end else if (ex_jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = ex_jump_addr_i;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        redirect      = 1'b1;
      end else if (lu) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
        lu_stall      = 1'b1;
      end else if (state_q == StDrain) begin
        pc_hold_o     = 1'b1;
        if_id_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      halt_ack_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (halt_req_i) begin
            state_q     <= StDrain;
            drain_cnt_q <= DcW'(DRAIN_CYCLES);
          end
        end
        StDrain: begin
          if (!halt_req_i) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
          end else if (!busy_stall && !lu_stall) begin
            // Stalled cycles do not move instructions toward WB, so they do not count
            if (drain_cnt_q <= DcW'(1)) begin
              state_q     <= StHalted;
              drain_cnt_q <= '0;
              halt_ack_q  <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - DcW'(1);
            end
          end
        end
        StHalted: begin
          if (!halt_req_i) begin
            state_q    <= StRun;
            halt_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StRun;
          drain_cnt_q <= '0;
          halt_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((busy_stall || lu_stall) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign halt_ack_o  = halt_ack_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each directed cycle queues its hand-computed expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 32;

  // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, jump_en}
  localparam logic [6:0] ONone = 7'b0000000;
  localparam logic [6:0] OBusy = 7'b1101010;
  localparam logic [6:0] OJump = 7'b0010101;
  localparam logic [6:0] OLu   = 7'b1100100;
  localparam logic [6:0] ODrn  = 7'b1010000;

  typedef struct packed {
    logic [6:0]      flags;
    logic [31:0]     addr;
    logic            ack;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [4:0]      id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic            id_rs1_used, id_rs2_used, ex_reg_wen, ex_is_load;
  logic            ex_jump_en, mem_busy, halt_req;
  logic [31:0]     ex_jump_addr;
  logic            pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold;
  logic            jump_en, halt_ack;
  logic [31:0]     jump_addr;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_cyc  = 0;

  pipe_ctrl #(
    .DRAIN_CYCLES (4),
    .CNT_W        (CntW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_reg_wen_i   (ex_reg_wen),
    .ex_is_load_i   (ex_is_load),
    .ex_jump_en_i   (ex_jump_en),
    .ex_jump_addr_i (ex_jump_addr),
    .mem_busy_i     (mem_busy),
    .halt_req_i     (halt_req),
    .pc_hold_o      (pc_hold),
    .if_id_hold_o   (if_id_hold),
    .if_id_flush_o  (if_id_flush),
    .id_ex_hold_o   (id_ex_hold),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_hold_o  (ex_mem_hold),
    .jump_en_o      (jump_en),
    .jump_addr_o    (jump_addr),
    .halt_ack_o     (halt_ack),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle presents a vector mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, jump_en};
      n_vec++;
      if (act !== e.flags || jump_addr !== e.addr || halt_ack !== e.ack ||
          stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        n_miss++;
        $display("FAIL cycle %0d: got flags=%b addr=%h ack=%b stall=%0d flush=%0d, want flags=%b addr=%h ack=%b stall=%0d flush=%0d",
                 n_cyc, act, jump_addr, halt_ack, stall_cnt, flush_cnt,
                 e.flags, e.addr, e.ack, e.stall, e.flush);
      end
    end
  end

  task automatic cyc(input logic [6:0] f, input logic [31:0] a, input logic k,
                     input int s, input int fl);
    exp_t e;
    e.flags = f;
    e.addr  = a;
    e.ack   = k;
    e.stall = CntW'(s);
    e.flush = CntW'(fl);
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic set_hz(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic ld);
    ex_rd_addr  = rd;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    ex_is_load  = ld;
    ex_reg_wen  = 1'b1;
  endtask

  task automatic clr_all();
    set_hz(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_reg_wen   = 1'b0;
    ex_jump_en   = 1'b0;
    ex_jump_addr = 32'd0;
    mem_busy     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    halt_req = 1'b0;
    clr_all();
    @(posedge clk);
    #1;
    cyc(ONone, 32'd0, 1'b0, 0, 0);          // in reset
    rst_n = 1'b1;
    cyc(ONone, 32'd0, 1'b0, 0, 0);

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID
    set_hz(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    cyc(OLu, 32'd0, 1'b0, 0, 0);
    clr_all();
    cyc(ONone, 32'd0, 1'b0, 1, 0);
    set_hz(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);  // rd = x0
    cyc(ONone, 32'd0, 1'b0, 1, 0);
    set_hz(5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1);  // rs2 match
    cyc(OLu, 32'd0, 1'b0, 1, 0);
    set_hz(5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1);  // rs2 not used
    cyc(ONone, 32'd0, 1'b0, 2, 0);
    set_hz(5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);  // not a load
    cyc(ONone, 32'd0, 1'b0, 2, 0);

    // Redirect wins over load-use
    set_hz(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    ex_jump_en   = 1'b1;
    ex_jump_addr = 32'h0000_0100;
    cyc(OJump, 32'h0000_0100, 1'b0, 2, 0);
    clr_all();
    cyc(ONone, 32'd0, 1'b0, 2, 1);

    // Memory wait freezes a pending redirect for 3 cycles
    mem_busy     = 1'b1;
    ex_jump_en   = 1'b1;
    ex_jump_addr = 32'h0000_0200;
    cyc(OBusy, 32'd0, 1'b0, 2, 1);
    cyc(OBusy, 32'd0, 1'b0, 3, 1);
    cyc(OBusy, 32'd0, 1'b0, 4, 1);
    mem_busy = 1'b0;
    cyc(OJump, 32'h0000_0200, 1'b0, 5, 1);
    clr_all();
    cyc(ONone, 32'd0, 1'b0, 5, 2);

    // Undisturbed halt: entry cycle, 4 drain cycles, then ack
    halt_req = 1'b1;
    cyc(ONone, 32'd0, 1'b0, 5, 2);
    for (int i = 0; i < 4; i++) cyc(ODrn, 32'd0, 1'b0, 5, 2);
    cyc(ODrn, 32'd0, 1'b1, 5, 2);
    mem_busy     = 1'b1;                          // ignored while halted
    ex_jump_en   = 1'b1;
    ex_jump_addr = 32'h0000_0400;
    set_hz(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    cyc(ODrn, 32'd0, 1'b1, 5, 2);
    clr_all();
    cyc(ODrn, 32'd0, 1'b1, 5, 2);
    halt_req = 1'b0;
    cyc(ODrn, 32'd0, 1'b1, 5, 2);
    cyc(ONone, 32'd0, 1'b0, 5, 2);

    // Drain with 2 busy cycles, one load-use and one redirect: ack 3 cycles later
    halt_req = 1'b1;
    cyc(ONone, 32'd0, 1'b0, 5, 2);
    mem_busy = 1'b1;
    cyc(OBusy, 32'd0, 1'b0, 5, 2);
    cyc(OBusy, 32'd0, 1'b0, 6, 2);
    mem_busy = 1'b0;
    cyc(ODrn, 32'd0, 1'b0, 7, 2);
    set_hz(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    cyc(OLu, 32'd0, 1'b0, 7, 2);
    clr_all();
    ex_jump_en   = 1'b1;
    ex_jump_addr = 32'h0000_0300;
    cyc(OJump, 32'h0000_0300, 1'b0, 8, 2);
    clr_all();
    cyc(ODrn, 32'd0, 1'b0, 8, 3);
    cyc(ODrn, 32'd0, 1'b0, 8, 3);
    cyc(ODrn, 32'd0, 1'b1, 8, 3);
    halt_req = 1'b0;
    cyc(ODrn, 32'd0, 1'b1, 8, 3);
    cyc(ONone, 32'd0, 1'b0, 8, 3);

    // Abort mid-drain: ack never rises
    halt_req = 1'b1;
    cyc(ONone, 32'd0, 1'b0, 8, 3);
    cyc(ODrn, 32'd0, 1'b0, 8, 3);
    halt_req = 1'b0;
    cyc(ODrn, 32'd0, 1'b0, 8, 3);
    for (int i = 0; i < 4; i++) cyc(ONone, 32'd0, 1'b0, 8, 3);

    // Async reset mid-drain with live hazards on the inputs
    halt_req = 1'b1;
    cyc(ONone, 32'd0, 1'b0, 8, 3);
    cyc(ODrn, 32'd0, 1'b0, 8, 3);
    mem_busy = 1'b1;
    cyc(OBusy, 32'd0, 1'b0, 8, 3);
    ex_jump_en   = 1'b1;
    ex_jump_addr = 32'h0000_0500;
    rst_n        = 1'b0;
    cyc(ONone, 32'd0, 1'b0, 0, 0);
    rst_n    = 1'b1;
    halt_req = 1'b0;
    clr_all();
    cyc(ONone, 32'd0, 1'b0, 0, 0);
    set_hz(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    cyc(OLu, 32'd0, 1'b0, 0, 0);
    clr_all();
    cyc(ONone, 32'd0, 1'b0, 1, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
